// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned BE_W           = XLEN / 8;
  localparam int unsigned FAIR_LIMIT_DEF = 4;

  localparam logic [1:0] LS_B = 2'd0;
  localparam logic [1:0] LS_H = 2'd1;
  localparam logic [1:0] LS_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  typedef struct packed {
    logic            owner_dm;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      size;
    logic            uns;
  } txn_t;

  // Halfwords need even addresses, words need 4-byte alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LS_H:    return off[0];
      LS_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_lsu_align.sv
// Byte-lane steering: write enables, store replication and load extraction/extension.
module lsu_align
  import mem_arbiter_pkg::*;
(
  input  logic            fetch,
  input  logic [1:0]      size,
  input  logic [1:0]      off,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted   = rdata >> {off, 3'b000};
    be        = '1;
    wdata_rep = wdata;
    load_data = shifted;
    case (size)
      LS_B: begin
        be        = BE_W'(4'b0001 << off);
        wdata_rep = {4{wdata[7:0]}};
        load_data = uns ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      LS_H: begin
        be        = BE_W'(4'b0011 << off);
        wdata_rep = {2{wdata[15:0]}};
        load_data = uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
    if (fetch) be = '1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto a single memory port, one access outstanding,
// with a starvation limit that eventually lets fetch past a stream of data requests.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT = FAIR_LIMIT_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  input  logic [1:0]      dm_size,
  input  logic            dm_unsigned,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_misaligned,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  localparam int unsigned SW = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;

  state_e          state, state_nxt;
  txn_t            txn;
  logic [SW-1:0]   starve;
  logic            fetch_turn_c, grant_dm_c, grant_if_c, dm_mis_c;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c, load_c;

  // Fetch overrides data only once it has been passed over FAIR_LIMIT times.
  assign fetch_turn_c = (FAIR_LIMIT > 0) && (starve == SW'(FAIR_LIMIT)) && if_req;
  assign grant_dm_c   = (state == ST_IDLE) && !reset && dm_req && !fetch_turn_c;
  assign grant_if_c   = (state == ST_IDLE) && !reset && if_req && !grant_dm_c;
  assign dm_mis_c     = is_misaligned(dm_size, dm_addr[1:0]);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_dm_c)      state_nxt = dm_mis_c ? ST_ERR : ST_REQ;
        else if (grant_if_c) state_nxt = ST_REQ;
      end
      ST_REQ:  if (mem_gnt)    state_nxt = ST_RESP;
      ST_RESP: if (mem_rvalid) state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Memory port is driven only while a request is in flight; otherwise all zeros.
  always_comb begin
    if_gnt    = grant_if_c;
    dm_gnt    = grant_dm_c;
    busy      = (state != ST_IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (state == ST_REQ) begin
      mem_req   = 1'b1;
      mem_we    = txn.we;
      mem_addr  = {txn.addr[XLEN-1:2], 2'b00};
      mem_be    = be_c;
      mem_wdata = wdata_c;
    end
  end

  lsu_align u_align (
    .fetch     (!txn.owner_dm),
    .size      (txn.size),
    .off       (txn.addr[1:0]),
    .uns       (txn.uns),
    .wdata     (txn.wdata),
    .rdata     (mem_rdata),
    .be        (be_c),
    .wdata_rep (wdata_c),
    .load_data (load_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      txn           <= '0;
      starve        <= '0;
      if_rvalid     <= 1'b0;
      if_rdata      <= '0;
      dm_rvalid     <= 1'b0;
      dm_rdata      <= '0;
      dm_misaligned <= 1'b0;
    end else begin
      if_rvalid     <= 1'b0;
      dm_rvalid     <= 1'b0;
      dm_misaligned <= 1'b0;
      if (grant_dm_c) begin
        txn <= '{owner_dm: 1'b1, we: dm_we, addr: dm_addr, wdata: dm_wdata,
                 size: dm_size, uns: dm_unsigned};
        if (if_req && (starve != SW'(FAIR_LIMIT))) starve <= starve + SW'(1);
      end else if (grant_if_c) begin
        txn <= '{owner_dm: 1'b0, we: 1'b0, addr: if_addr, wdata: XLEN'(0),
                 size: LS_W, uns: 1'b0};
        starve <= '0;
      end
      if ((state == ST_RESP) && mem_rvalid) begin
        if (txn.owner_dm) begin
          dm_rvalid <= 1'b1;
          dm_rdata  <= txn.we ? XLEN'(0) : load_c;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end
      if (state == ST_ERR) begin
        dm_rvalid     <= 1'b1;
        dm_misaligned <= 1'b1;
        dm_rdata      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: memory responder, completion monitor, directed and random traffic.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_unsigned, dm_gnt, dm_rvalid, dm_misaligned;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [1:0]  dm_size;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  typedef struct { bit is_dm; logic [31:0] rdata; bit mis; } exp_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; bit chk_wd; bit we; logic [31:0] rdata; } mexp_t;

  exp_t  exp_q[$];
  mexp_t mem_q[$];

  int n_total = 0, n_bad = 0;
  int cyc = 0, gnt_cyc = 0, rv_cyc = 0, rv_count = 0, mem_req_cycles = 0;
  int gnt_delay = 0, rv_extra = 0;

  mem_arbiter #(.FAIR_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size),
    .dm_unsigned(dm_unsigned), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dm_misaligned(dm_misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_mis(input logic [1:0] size, input logic [1:0] off);
    return (int'(off) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= int'(off)) && (i < int'(off) + nbytes(size));
    return be;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % nbytes(size)) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] ref_ld(input logic [1:0] size, input logic [1:0] off,
                                         input bit uns, input logic [31:0] mrd);
    logic [31:0] v = '0;
    int nb = nbytes(size);
    for (int j = 0; j < nb; j++) v[8*j +: 8] = mrd[8*(int'(off) + j) +: 8];
    if (!uns && v[8*nb-1]) for (int k = 8*nb; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  // Completion monitor and memory responder share one negedge process.
  initial begin
    exp_t  e;
    mexp_t m;
    bit    pend = 0;
    int    wait_cnt = 0, rv_wait = 0;
    logic [31:0] pend_rdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_req === 1'b1) mem_req_cycles++;
      if (busy === 1'b1 && (if_gnt === 1'b1 || dm_gnt === 1'b1))
        check_eq("gnt_while_busy", 32'(if_gnt | dm_gnt), 0);
      if (dm_misaligned === 1'b1 && dm_rvalid !== 1'b1)
        check_eq("mis_without_rvalid", 32'(dm_misaligned), 0);
      if (if_rvalid === 1'b1 || dm_rvalid === 1'b1) begin
        rv_count++;
        rv_cyc = cyc;
        check_eq("rv_exclusive", 32'(if_rvalid & dm_rvalid), 0);
        check_eq("rv_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rv_owner", 32'(dm_rvalid), 32'(e.is_dm));
          check_eq("rv_rdata", e.is_dm ? dm_rdata : if_rdata, e.rdata);
          check_eq("rv_misaligned", 32'(dm_misaligned), 32'(e.mis));
        end
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (pend) begin
        if (rv_wait >= rv_extra) begin
          mem_rvalid = 1'b1; mem_rdata = pend_rdata; pend = 0; rv_wait = 0;
        end else rv_wait++;
      end else if (mem_req === 1'b1) begin
        if (wait_cnt >= gnt_delay) begin
          wait_cnt = 0;
          check_eq("mem_req_expected", 32'(mem_q.size() != 0), 1);
          if (mem_q.size() != 0) begin
            m = mem_q.pop_front();
            check_eq("mem_addr", mem_addr, m.addr);
            check_eq("mem_be", 32'(mem_be), 32'(m.be));
            check_eq("mem_we", 32'(mem_we), 32'(m.we));
            if (m.chk_wd) check_eq("mem_wdata", mem_wdata, m.wdata);
            mem_gnt = 1'b1; pend = 1; pend_rdata = m.rdata;
          end
        end else wait_cnt++;
      end
    end
  end

  task automatic wait_gnt(input bit is_dm, output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if ((is_dm ? dm_gnt : if_gnt) === 1'b1) begin
        ok = 1;
        gnt_cyc = cyc;
      end else @(negedge clock);
    end
    check_eq("gnt_seen", 32'(ok), 1);
    if (ok) begin @(posedge clock); #1; end
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock); #2;
      if (exp_q.size() == 0 && mem_q.size() == 0 && busy === 1'b0) done = 1;
    end
    check_eq("txn_done", 32'(done), 1);
    if (!done) begin exp_q.delete(); mem_q.delete(); end
  endtask

  task automatic if_op(input logic [31:0] addr, input logic [31:0] mrd);
    bit ok; exp_t e; mexp_t m;
    m.addr = {addr[31:2], 2'b00}; m.be = 4'hF; m.wdata = '0; m.chk_wd = 0; m.we = 0; m.rdata = mrd;
    mem_q.push_back(m);
    e.is_dm = 0; e.rdata = mrd; e.mis = 0;
    exp_q.push_back(e);
    @(negedge clock);
    if_req = 1'b1; if_addr = addr;
    wait_gnt(1'b0, ok);
    if_req = 1'b0;
    wait_done();
  endtask

  task automatic dm_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input bit uns, input logic [31:0] mrd,
                       input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd,
                       input bit emis);
    bit ok; exp_t e; mexp_t m;
    if (!emis) begin
      m.addr = {addr[31:2], 2'b00}; m.be = ebe; m.wdata = ewd; m.chk_wd = we; m.we = we; m.rdata = mrd;
      mem_q.push_back(m);
    end
    e.is_dm = 1; e.rdata = erd; e.mis = emis;
    exp_q.push_back(e);
    @(negedge clock);
    dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_size = size; dm_unsigned = uns;
    wait_gnt(1'b1, ok);
    dm_req = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int mrq0, rc0, n;
    logic [31:0] seq;
    exp_t e; mexp_t m;
    reset = 1'b1; if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_size = 2'd0; dm_unsigned = 0;

    repeat (3) @(negedge clock);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_mem_req", 32'(mem_req), 0);
    check_eq("rst_mem_we", 32'(mem_we), 0);
    check_eq("rst_mem_be", 32'(mem_be), 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_if_rvalid", 32'(if_rvalid), 0);
    check_eq("rst_dm_rvalid", 32'(dm_rvalid), 0);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_dm_rdata", dm_rdata, 0);
    check_eq("rst_dm_mis", 32'(dm_misaligned), 0);
    reset = 1'b0;

    if_op(32'h0000_0100, 32'h0050_0093);
    check_eq("fetch_latency", 32'(rv_cyc - gnt_cyc), 3);
    gnt_delay = 2;
    if_op(32'h0000_0107, 32'hCAFE_F00D);
    gnt_delay = 0;

    dm_op(1'b0, 32'h203, 32'h0, 2'd0, 1'b0, 32'h80FF_FFFF, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0);
    check_eq("load_latency", 32'(rv_cyc - gnt_cyc), 3);
    dm_op(1'b0, 32'h203, 32'h0, 2'd0, 1'b1, 32'h80FF_FFFF, 4'b1000, 32'h0, 32'h0000_0080, 1'b0);
    dm_op(1'b1, 32'h302, 32'h1234_ABCD, 2'd1, 1'b0, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);

    mrq0 = mem_req_cycles;
    dm_op(1'b0, 32'h401, 32'h0, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1);
    check_eq("mis_latency", 32'(rv_cyc - gnt_cyc), 2);
    dm_op(1'b1, 32'h301, 32'hFFFF_FFFF, 2'd1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1);
    check_eq("mis_no_mem_req", 32'(mem_req_cycles), 32'(mrq0));

    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, wd, mrd;
      logic [1:0] sz;
      bit we, uns, mis;
      gnt_delay = $urandom_range(0, 2);
      a = $urandom; wd = $urandom; mrd = $urandom;
      if ($urandom_range(0, 3) == 0) if_op(a, mrd);
      else begin
        sz = 2'($urandom_range(0, 2)); we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
        mis = ref_mis(sz, a[1:0]);
        dm_op(we, a, wd, sz, uns, mrd, ref_be(sz, a[1:0]), ref_wd(sz, wd),
              (mis || we) ? 32'h0 : ref_ld(sz, a[1:0], uns, mrd), mis);
      end
    end
    gnt_delay = 0;

    // Both ports requesting continuously: fairness window of four data grants.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h500;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600; dm_size = 2'd2; dm_unsigned = 1'b0;
    n = 0; seq = '0;
    for (int c = 0; c < 300 && n < 10; c++) begin
      #1;
      if (dm_gnt === 1'b1 || if_gnt === 1'b1) begin
        m.be = 4'hF; m.wdata = '0; m.chk_wd = 0; m.we = 0;
        e.mis = 0;
        if (dm_gnt === 1'b1) begin
          m.addr = 32'h600; m.rdata = 32'hD000_0000 | 32'(n); e.is_dm = 1;
        end else begin
          m.addr = 32'h500; m.rdata = 32'h1000_0000 | 32'(n); e.is_dm = 0;
        end
        e.rdata = m.rdata;
        mem_q.push_back(m); exp_q.push_back(e);
        seq = {seq[30:0], dm_gnt};
        n++;
      end
      if (n < 10) @(negedge clock);
    end
    @(posedge clock); #1;
    if_req = 1'b0; dm_req = 1'b0;
    check_eq("fair_grants", 32'(n), 10);
    check_eq("fair_pattern", seq, 32'h3DE);
    wait_done();

    // Reset while waiting in RESP; the late memory response must be dropped.
    rv_extra = 4;
    rc0 = rv_count;
    m.addr = 32'h700; m.be = 4'hF; m.wdata = '0; m.chk_wd = 0; m.we = 0; m.rdata = 32'hDEAD_BEEF;
    mem_q.push_back(m);
    @(negedge clock);
    if_req = 1'b1; if_addr = 32'h700;
    begin
      bit ok;
      wait_gnt(1'b0, ok);
    end
    if_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_eq("busy_in_resp", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("rst_resp_busy", 32'(busy), 0);
    repeat (10) @(negedge clock);
    check_eq("rst_resp_no_rvalid", 32'(rv_count), 32'(rc0));
    check_eq("rst_resp_idle", 32'(busy), 0);
    check_eq("rst_resp_mem_q", 32'(mem_q.size()), 0);
    rv_extra = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
